// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// Holds the fetch FSM/vector-select enums and the instruction-group codes the IF stage decodes.
package cpu_pkg;

  localparam logic [15:0] BUBBLE_INSTR = 16'h07F8;
  localparam logic [2:0]  FUNC_IMM     = 3'b100;
  localparam logic [2:0]  FUNC_JMP     = 3'b110;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2
  } fetch_state_t;

  typedef enum logic {
    RST = 1'b0,
    IVT = 1'b1
  } vec_sel_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the IF stage's memory, control, IF/ID and debug signals.
// if_valid qualifies if_instr; there is no ready, stall is the only backpressure and it holds IF/ID.
interface fetch_unit_if #(
  parameter int AW = 20
);
  import cpu_pkg::*;

  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic          stall;
  logic          flush;
  logic [31:0]   br_target;
  logic          int_raised_instr;
  logic [15:0]   int_instr;
  logic          int_raised_to_fetch;
  logic [15:0]   if_instr;
  logic [31:0]   if_pc;
  logic [31:0]   next_pc;
  logic [2:0]    func_bits;
  logic          is_jmp;
  logic          if_valid;
  logic          if_imm_word;
  fetch_state_t  dbg_state;
  logic [31:0]   dbg_pc;

  modport master (
    output imem_addr, if_instr, if_pc, next_pc, func_bits, is_jmp, if_valid, if_imm_word,
           dbg_state, dbg_pc,
    input  imem_data, stall, flush, br_target, int_raised_instr, int_instr, int_raised_to_fetch
  );

  modport slave (
    input  imem_addr, if_instr, if_pc, next_pc, func_bits, is_jmp, if_valid, if_imm_word,
           dbg_state, dbg_pc,
    output imem_data, stall, flush, br_target, int_raised_instr, int_instr, int_raised_to_fetch
  );

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: bubble has priority over load; with neither asserted every field holds.
// A bubble keeps if_pc/next_pc so the last real PC stays visible to the interrupt logic.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble_i,
  input  logic        load_i,
  input  logic [15:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] npc_i,
  input  logic        valid_i,
  input  logic        imm_i,
  input  logic [2:0]  func_i,
  input  logic        jmp_i,
  output logic [15:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o,
  output logic        valid_o,
  output logic        imm_o,
  output logic [2:0]  func_o,
  output logic        jmp_o
);

  logic [15:0] instr_q;
  logic [31:0] pc_q, npc_q;
  logic        valid_q, imm_q, jmp_q;
  logic [2:0]  func_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= BUBBLE_INSTR;
      pc_q    <= 32'd0;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
      imm_q   <= 1'b0;
      func_q  <= 3'd0;
      jmp_q   <= 1'b0;
    end else if (bubble_i) begin
      instr_q <= BUBBLE_INSTR;
      valid_q <= 1'b0;
      imm_q   <= 1'b0;
      func_q  <= 3'd0;
      jmp_q   <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      npc_q   <= npc_i;
      valid_q <= valid_i;
      imm_q   <= imm_i;
      func_q  <= func_i;
      jmp_q   <= jmp_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;
  assign imm_o   = imm_q;
  assign func_o  = func_q;
  assign jmp_o   = jmp_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, loads reset/IVT vectors, fetches sequentially or from a branch target,
// and merges interrupt-injected words into the IF/ID register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          IMEM_AW = 20,
  parameter logic [31:0] RST_VEC = 32'h0,
  parameter logic [31:0] IVT_VEC = 32'h2
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_t       state_q, state_d;
  vec_sel_t           vec_sel_q, vec_sel_d;
  logic [31:0]        pc_q, pc_d, pc_inc;
  logic [15:0]        lo_q, lo_d;
  logic               imm_pend_q, imm_pend_d;
  logic [IMEM_AW-1:0] vec_addr, addr_w;

  logic        bubble, load, ld_valid, ld_imm, ld_jmp;
  logic [15:0] ld_instr;
  logic [31:0] ld_pc, ld_npc;
  logic [2:0]  ld_func, data_func;
  logic [15:0] r_instr;
  logic [31:0] r_pc, r_npc;
  logic [2:0]  r_func;
  logic        r_valid, r_imm, r_jmp;

  assign pc_inc    = pc_q + 32'd1;
  assign vec_addr  = (vec_sel_q == RST) ? RST_VEC[IMEM_AW-1:0] : IVT_VEC[IMEM_AW-1:0];
  assign data_func = bus.imem_data[15:13];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= VEC_LO;
      vec_sel_q  <= RST;
      pc_q       <= 32'd0;
      lo_q       <= 16'd0;
      imm_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_sel_q  <= vec_sel_d;
      pc_q       <= pc_d;
      lo_q       <= lo_d;
      imm_pend_q <= imm_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_sel_d  = vec_sel_q;
    pc_d       = pc_q;
    lo_d       = lo_q;
    imm_pend_d = imm_pend_q;
    addr_w     = pc_q[IMEM_AW-1:0];
    bubble     = 1'b0;
    load       = 1'b0;
    // Default load payload is a sequential memory fetch; the imm word's group bits are data, not opcode.
    ld_instr   = bus.imem_data;
    ld_pc      = pc_q;
    ld_npc     = pc_inc;
    ld_valid   = 1'b1;
    ld_imm     = imm_pend_q;
    ld_func    = imm_pend_q ? 3'd0 : data_func;
    ld_jmp     = !imm_pend_q && (data_func == FUNC_JMP);
    case (state_q)
      VEC_LO: begin
        addr_w  = vec_addr;
        lo_d    = bus.imem_data;
        state_d = VEC_HI;
        bubble  = 1'b1;
      end
      VEC_HI: begin
        addr_w  = vec_addr + IMEM_AW'(1);
        pc_d    = {bus.imem_data, lo_q};
        state_d = RUN;
        bubble  = 1'b1;
      end
      default: begin
        if (bus.int_raised_to_fetch) begin
          vec_sel_d  = IVT;
          state_d    = VEC_LO;
          bubble     = 1'b1;
          imm_pend_d = 1'b0;
        end else if (bus.flush) begin
          pc_d       = bus.br_target;
          bubble     = 1'b1;
          imm_pend_d = 1'b0;
        end else if (bus.int_raised_instr) begin
          load     = 1'b1;
          ld_instr = bus.int_instr;
          ld_npc   = r_npc;
          ld_valid = (bus.int_instr != BUBBLE_INSTR);
          ld_imm   = 1'b0;
          ld_func  = bus.int_instr[15:13];
          ld_jmp   = 1'b0;
        end else if (!bus.stall) begin
          load       = 1'b1;
          pc_d       = pc_inc;
          imm_pend_d = !imm_pend_q && (data_func == FUNC_IMM);
        end
      end
    endcase
  end

  ifid_reg u_ifid (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (bubble),
    .load_i   (load),
    .instr_i  (ld_instr),
    .pc_i     (ld_pc),
    .npc_i    (ld_npc),
    .valid_i  (ld_valid),
    .imm_i    (ld_imm),
    .func_i   (ld_func),
    .jmp_i    (ld_jmp),
    .instr_o  (r_instr),
    .pc_o     (r_pc),
    .npc_o    (r_npc),
    .valid_o  (r_valid),
    .imm_o    (r_imm),
    .func_o   (r_func),
    .jmp_o    (r_jmp)
  );

  assign bus.imem_addr   = addr_w;
  assign bus.if_instr    = r_instr;
  assign bus.if_pc       = r_pc;
  assign bus.next_pc     = r_npc;
  assign bus.func_bits   = r_func;
  assign bus.is_jmp      = r_jmp;
  assign bus.if_valid    = r_valid;
  assign bus.if_imm_word = r_imm;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_pc      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random control traffic,
// compared every cycle against a behavioural model of the IF stage.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int          AW      = 20;
  localparam logic [31:0] RST_VEC = 32'h0;
  localparam logic [31:0] IVT_VEC = 32'h2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  fetch_unit_if #(.AW(AW)) bus ();

  fetch_unit #(.IMEM_AW(AW), .RST_VEC(RST_VEC), .IVT_VEC(IVT_VEC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory, aliased on the low 12 address bits
  logic [15:0] mem [4096];
  always_comb bus.imem_data = mem[bus.imem_addr[11:0]];

  // reference model
  int          m_phase;
  logic [31:0] m_vbase, m_pc;
  logic [15:0] m_lo;
  bit          m_pend;
  logic [15:0] e_instr;
  logic [31:0] e_pc, e_npc;
  logic        e_valid, e_imm, e_jmp;
  logic [2:0]  e_func;

  function automatic logic [31:0] model_addr();
    logic [31:0] a;
    if (m_phase == 0)      a = m_vbase;
    else if (m_phase == 1) a = m_vbase + 32'd1;
    else                   a = m_pc;
    return a & ((32'd1 << AW) - 32'd1);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_vbase = RST_VEC; m_pc = 0; m_lo = 0; m_pend = 0;
    e_instr = BUBBLE_INSTR; e_pc = 0; e_npc = 0;
    e_valid = 0; e_imm = 0; e_jmp = 0; e_func = 0;
  endtask

  task automatic model_bubble();
    e_instr = BUBBLE_INSTR; e_valid = 0; e_imm = 0; e_func = 0; e_jmp = 0;
  endtask

  task automatic model_step(input bit st, input bit fl, input logic [31:0] tgt,
                            input bit inj, input logic [15:0] iw, input bit irf,
                            input logic [15:0] d);
    int grp;
    grp = int'(d >> 13);
    if (m_phase == 0) begin
      m_lo = d; m_phase = 1; model_bubble();
    end else if (m_phase == 1) begin
      m_pc = {d, m_lo}; m_phase = 2; model_bubble();
    end else if (irf) begin
      m_vbase = IVT_VEC; m_phase = 0; m_pend = 0; model_bubble();
    end else if (fl) begin
      m_pc = tgt; m_pend = 0; model_bubble();
    end else if (inj) begin
      e_instr = iw; e_pc = m_pc; e_valid = (iw != 16'h07F8);
      e_imm = 0; e_func = iw[15:13]; e_jmp = 0;
    end else if (!st) begin
      e_instr = d; e_pc = m_pc; e_npc = m_pc + 32'd1; e_valid = 1;
      e_imm   = m_pend;
      e_func  = m_pend ? 3'd0 : 3'(grp);
      e_jmp   = !m_pend && (grp == 6);
      m_pend  = !m_pend && (grp == 4);
      m_pc    = m_pc + 32'd1;
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".instr"}, 32'(bus.if_instr), 32'(e_instr));
    chk({tag, ".pc"},    bus.if_pc, e_pc);
    chk({tag, ".npc"},   bus.next_pc, e_npc);
    chk({tag, ".valid"}, 32'(bus.if_valid), 32'(e_valid));
    chk({tag, ".imm"},   32'(bus.if_imm_word), 32'(e_imm));
    chk({tag, ".func"},  32'(bus.func_bits), 32'(e_func));
    chk({tag, ".jmp"},   32'(bus.is_jmp), 32'(e_jmp));
    chk({tag, ".addr"},  32'(bus.imem_addr), model_addr());
    chk({tag, ".state"}, 32'(bus.dbg_state), 32'(m_phase));
    chk({tag, ".pcreg"}, bus.dbg_pc, m_pc);
  endtask

  // driver: apply one cycle of controls, advance model with the edge, check at negedge
  task automatic step(input bit st, input bit fl, input logic [31:0] tgt, input bit inj,
                      input logic [15:0] iw, input bit irf, input string tag);
    logic [31:0] a;
    logic [15:0] d;
    bus.stall = st; bus.flush = fl; bus.br_target = tgt;
    bus.int_raised_instr = inj; bus.int_instr = iw; bus.int_raised_to_fetch = irf;
    a = model_addr();
    d = mem[a[11:0]];
    @(posedge clk);
    model_step(st, fl, tgt, inj, iw, irf, d);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 32'd0, 0, 16'h0, 0, tag);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0010; mem[1] = 16'h0000;
    mem[2] = 16'h0200; mem[3] = 16'h0000;
    mem[16'h10] = 16'h8001; mem[16'h11] = 16'h0005; mem[16'h12] = 16'h2345;
    mem[16'h40] = 16'h8ABC; mem[16'h41] = 16'hC00F;
    rst_n = 1'b0;
    bus.stall = 0; bus.flush = 0; bus.br_target = 0;
    bus.int_raised_instr = 0; bus.int_instr = 0; bus.int_raised_to_fetch = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // reset vector load, then sequential fetch with an IMM pair
    idle("vec_lo");
    idle("vec_hi");
    idle("fetch10");
    chk("first_pc", bus.if_pc, 32'h10);
    idle("fetch11");
    chk("imm_word", 32'(bus.if_imm_word), 32'd1);
    idle("fetch12");
    step(1, 0, 32'd0, 0, 16'h0, 0, "stall");
    chk("stall_hold", 32'(bus.if_instr), 32'h2345);

    // injection keeps PC frozen; JMP-looking part 2 must not assert is_jmp
    step(0, 0, 32'd0, 1, 16'h07F8, 0, "inj_bub");
    step(0, 0, 32'd0, 1, 16'hF480, 0, "inj_p1");
    step(0, 0, 32'd0, 1, 16'hC123, 0, "inj_p2");
    chk("inj_npc", bus.next_pc, 32'h13);

    // IVT vector load
    step(0, 0, 32'd0, 0, 16'h0, 1, "ivt_pulse");
    idle("ivt_lo");
    idle("ivt_hi");
    idle("ivt_fetch");
    chk("ivt_pc", bus.if_pc, 32'h200);

    // flush beats injection, then IMM flag survives stall and injection
    step(0, 1, 32'h40, 1, 16'hF480, 0, "flush_inj");
    idle("fetch40");
    chk("flush_pc", bus.if_pc, 32'h40);
    step(1, 0, 32'd0, 0, 16'h0, 0, "imm_stall");
    step(0, 0, 32'd0, 1, 16'h1234, 0, "imm_inj");
    idle("fetch41");
    chk("imm_survive", 32'(bus.if_imm_word), 32'd1);
    chk("imm_nojmp", 32'(bus.is_jmp), 32'd0);

    // PC wrap
    step(0, 1, 32'hFFFF_FFFF, 0, 16'h0, 0, "flush_wrap");
    idle("fetch_wrap");
    chk("wrap_npc", bus.next_pc, 32'h0);

    // async reset during VEC_HI of an IVT load
    step(0, 0, 32'd0, 0, 16'h0, 1, "ivt2_pulse");
    idle("ivt2_lo");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle("rvec_lo");
    idle("rvec_hi");
    idle("rvec_fetch");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit          st, fl, inj, irf;
      logic [31:0] tgt;
      logic [15:0] iw;
      st  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      inj = ($urandom_range(0, 6) == 0);
      irf = ($urandom_range(0, 39) == 0);
      iw  = ($urandom_range(0, 2) == 0) ? 16'h07F8 : 16'($urandom);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                        : 32'($urandom_range(0, 4095));
      step(st, fl, tgt, inj, iw, irf, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
